// File: rtl/sdram_burst_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_burst_arb
//  Description : Burst scheduler between the audio record/playback FIFOs and
//                the SDRAM controller command port. Arbitrates between write
//                (record) and read (playback) bursts from the FIFO fill levels,
//                issues one command at a time and owns the wrapping write and
//                read address pointers.
//  Ports       : clk, rst                 - control clock, sync active-high reset
//                init_done, rd_valid      - SDRAM ready / playback enable
//                wr_load, rd_load         - restart pointer at region minimum
//                wr_fifo_cnt, rd_fifo_cnt - FIFO fill levels
//                wr/rd_min/max_addr       - pointer regions (max exclusive)
//                burst_len                - words per burst (0 blocks grants)
//                cmd_ack, burst_done      - controller handshake
//                cmd_wr, cmd_rd, cmd_addr, cmd_len - command to controller
//                wr_addr, rd_addr, busy   - pointer and activity status
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_burst_arb #(
    parameter int ADDR_W     = 24,
    parameter int CNT_W      = 10,
    parameter int FIFO_DEPTH = 1024,
    parameter int WR_URGENT  = 768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              rd_valid,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic [CNT_W-1:0]  wr_fifo_cnt,
    input  logic [CNT_W-1:0]  rd_fifo_cnt,
    input  logic [ADDR_W-1:0] wr_min_addr,
    input  logic [ADDR_W-1:0] wr_max_addr,
    input  logic [ADDR_W-1:0] rd_min_addr,
    input  logic [ADDR_W-1:0] rd_max_addr,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              cmd_ack,
    input  logic              burst_done,
    output logic              cmd_wr,
    output logic              cmd_rd,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [CNT_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_req   = 2'd1;
    localparam logic [1:0] c_st_burst = 2'd2;

    localparam logic [CNT_W:0]   c_fifo_depth = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_wr_urgent  = CNT_W'(WR_URGENT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              r_cmd_wr;
    logic              r_cmd_rd;
    logic              r_busy;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [CNT_W-1:0]  r_cmd_len;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_dir_wr;    // direction of the transaction in flight
    logic              r_last_wr;   // 1 = last grant was a write
    logic              r_wr_pend;   // deferred wr_load for an in-flight write
    logic              r_rd_pend;   // deferred rd_load for an in-flight read

    logic              w_gate;
    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_wr_urgent;
    logic [CNT_W:0]    w_rd_sum;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_take_grant;
    logic              w_finish;
    logic              w_wr_in_flight;
    logic              w_rd_in_flight;
    logic [ADDR_W:0]   w_wr_sum;
    logic [ADDR_W:0]   w_rd_next_sum;
    logic [ADDR_W-1:0] w_wr_step;
    logic [ADDR_W-1:0] w_rd_step;

    // ------------------------------------------------------------------------
    // Eligibility and arbitration (only acted upon in IDLE)
    // ------------------------------------------------------------------------
    assign w_gate      = init_done && (burst_len != '0);
    assign w_wr_elig   = w_gate && (wr_fifo_cnt >= burst_len);
    // rd_fifo_cnt <= FIFO_DEPTH - burst_len, rearranged as a sum so that a
    // burst_len larger than the FIFO cannot underflow.
    assign w_rd_sum    = {1'b0, rd_fifo_cnt} + {1'b0, burst_len};
    assign w_rd_elig   = w_gate && rd_valid && (w_rd_sum <= c_fifo_depth);
    assign w_wr_urgent = w_gate && (wr_fifo_cnt >= c_wr_urgent);

    // Urgent write overrides; on a tie the direction not granted last wins.
    assign w_grant_wr  = w_wr_urgent || (w_wr_elig && (!w_rd_elig || !r_last_wr));
    assign w_grant_rd  = !w_grant_wr && w_rd_elig;

    assign w_take_grant = (r_state == c_st_idle) && (w_grant_wr || w_grant_rd);
    assign w_finish     = (r_state == c_st_burst) && burst_done;

    assign w_wr_in_flight = (r_state != c_st_idle) && r_dir_wr;
    assign w_rd_in_flight = (r_state != c_st_idle) && !r_dir_wr;

    // ------------------------------------------------------------------------
    // Pointer advance, one bit wider so the wrap compare cannot overflow
    // ------------------------------------------------------------------------
    assign w_wr_sum      = {1'b0, r_wr_addr} + (ADDR_W+1)'(r_cmd_len);
    assign w_rd_next_sum = {1'b0, r_rd_addr} + (ADDR_W+1)'(r_cmd_len);
    assign w_wr_step     = (w_wr_sum >= {1'b0, wr_max_addr}) ? wr_min_addr
                                                             : w_wr_sum[ADDR_W-1:0];
    assign w_rd_step     = (w_rd_next_sum >= {1'b0, rd_max_addr}) ? rd_min_addr
                                                                  : w_rd_next_sum[ADDR_W-1:0];

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_grant_wr || w_grant_rd) begin
                    w_state_nxt = c_st_req;
                end
            end
            c_st_req: begin
                if (cmd_ack) begin
                    w_state_nxt = c_st_burst;
                end
            end
            c_st_burst: begin
                if (burst_done) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Command register and status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_wr   <= 1'b0;
            r_cmd_rd   <= 1'b0;
            r_busy     <= 1'b0;
            r_cmd_addr <= '0;
            r_cmd_len  <= '0;
            r_dir_wr   <= 1'b0;
            r_last_wr  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != c_st_idle);
            if (w_take_grant) begin
                r_cmd_wr   <= w_grant_wr;
                r_cmd_rd   <= !w_grant_wr;
                r_cmd_addr <= w_grant_wr ? r_wr_addr : r_rd_addr;
                r_cmd_len  <= burst_len;
                r_dir_wr   <= w_grant_wr;
                r_last_wr  <= w_grant_wr;
            end else if ((r_state == c_st_req) && cmd_ack) begin
                r_cmd_wr <= 1'b0;
                r_cmd_rd <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Address pointers. A load aimed at the in-flight direction is held off
    // until burst_done so the pointer always matches cmd_addr mid-transaction.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr <= wr_min_addr;
            r_wr_pend <= 1'b0;
        end else if (w_finish && r_dir_wr) begin
            r_wr_addr <= (r_wr_pend || wr_load) ? wr_min_addr : w_wr_step;
            r_wr_pend <= 1'b0;
        end else if (wr_load) begin
            if (w_wr_in_flight) begin
                r_wr_pend <= 1'b1;
            end else begin
                r_wr_addr <= wr_min_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr <= rd_min_addr;
            r_rd_pend <= 1'b0;
        end else if (w_finish && !r_dir_wr) begin
            r_rd_addr <= (r_rd_pend || rd_load) ? rd_min_addr : w_rd_step;
            r_rd_pend <= 1'b0;
        end else if (rd_load) begin
            if (w_rd_in_flight) begin
                r_rd_pend <= 1'b1;
            end else begin
                r_rd_addr <= rd_min_addr;
            end
        end
    end

    assign cmd_wr   = r_cmd_wr;
    assign cmd_rd   = r_cmd_rd;
    assign cmd_addr = r_cmd_addr;
    assign cmd_len  = r_cmd_len;
    assign wr_addr  = r_wr_addr;
    assign rd_addr  = r_rd_addr;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_burst_arb
//  Description : Directed self-checking bench for sdram_burst_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_burst_arb;

    localparam int ADDR_W = 24;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_done;
    logic              rd_valid;
    logic              wr_load;
    logic              rd_load;
    logic [CNT_W-1:0]  wr_fifo_cnt;
    logic [CNT_W-1:0]  rd_fifo_cnt;
    logic [ADDR_W-1:0] wr_min_addr;
    logic [ADDR_W-1:0] wr_max_addr;
    logic [ADDR_W-1:0] rd_min_addr;
    logic [ADDR_W-1:0] rd_max_addr;
    logic [CNT_W-1:0]  burst_len;
    logic              cmd_ack;
    logic              burst_done;
    logic              cmd_wr;
    logic              cmd_rd;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdram_burst_arb #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DEPTH(1024), .WR_URGENT(768)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .rd_valid(rd_valid),
        .wr_load(wr_load), .rd_load(rd_load),
        .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
        .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr),
        .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr),
        .burst_len(burst_len), .cmd_ack(cmd_ack), .burst_done(burst_done),
        .cmd_wr(cmd_wr), .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled at the negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_grant(input string tag, input bit exp_wr, input logic [31:0] exp_addr);
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cmd_wr || cmd_rd) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, ".grant_seen"}, 32'(seen), 32'd1);
        chk({tag, ".cmd_wr"}, 32'(cmd_wr), 32'(exp_wr));
        chk({tag, ".cmd_rd"}, 32'(cmd_rd), 32'(!exp_wr));
        chk({tag, ".cmd_addr"}, 32'(cmd_addr), exp_addr);
        chk({tag, ".cmd_len"}, 32'(cmd_len), 32'(burst_len));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    task automatic ack_phase(input string tag, input logic [31:0] exp_addr);
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        chk({tag, ".cmd_off"}, 32'(cmd_wr | cmd_rd), 32'd0);
        chk({tag, ".busy_burst"}, 32'(busy), 32'd1);
        chk({tag, ".addr_hold"}, 32'(cmd_addr), exp_addr);
    endtask

    task automatic done_phase(input string tag);
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
        chk({tag, ".idle_gap"}, 32'(busy), 32'd0);
    endtask

    task automatic run_burst(input string tag, input bit exp_wr, input logic [31:0] exp_addr);
        wait_grant(tag, exp_wr, exp_addr);
        ack_phase(tag, exp_addr);
        done_phase(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;  init_done = 1'b0; rd_valid = 1'b0;
        wr_load = 1'b0; rd_load = 1'b0;
        wr_fifo_cnt = '0; rd_fifo_cnt = '0;
        wr_min_addr = 24'd0; wr_max_addr = 24'd5760000;
        rd_min_addr = 24'd0; rd_max_addr = 24'd5760000;
        burst_len = 10'd512; cmd_ack = 1'b0; burst_done = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // reset values
        chk("rst.cmd_wr", 32'(cmd_wr), 32'd0);
        chk("rst.cmd_rd", 32'(cmd_rd), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rst.cmd_len", 32'(cmd_len), 32'd0);
        chk("rst.wr_addr", 32'(wr_addr), 32'd0);
        chk("rst.rd_addr", 32'(rd_addr), 32'd0);

        // both directions would be eligible, but init_done low blocks grants
        wr_fifo_cnt = 10'd600; rd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("noinit.cmd", 32'(cmd_wr | cmd_rd | busy), 32'd0);
        end
        // burst_len of zero blocks grants
        init_done = 1'b1; burst_len = 10'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("len0.cmd", 32'(cmd_wr | cmd_rd | busy), 32'd0);
        end

        // single write burst, then an immediate second one after one IDLE cycle
        burst_len = 10'd512; wr_fifo_cnt = 10'd512; rd_valid = 1'b0;
        run_burst("w1", 1'b1, 32'd0);
        chk("w1.wr_addr", 32'(wr_addr), 32'd512);
        run_burst("w2", 1'b1, 32'd512);
        chk("w2.wr_addr", 32'(wr_addr), 32'd1024);

        // a lone read sets last_grant = read
        wr_fifo_cnt = 10'd0; rd_valid = 1'b1; rd_fifo_cnt = 10'd0;
        run_burst("r1", 1'b0, 32'd0);
        chk("r1.rd_addr", 32'(rd_addr), 32'd512);

        // both eligible: alternation W, R, W, R
        wr_fifo_cnt = 10'd600;
        run_burst("alt1", 1'b1, 32'd1024);
        run_burst("alt2", 1'b0, 32'd512);
        run_burst("alt3", 1'b1, 32'd1536);
        run_burst("alt4", 1'b0, 32'd1024);
        chk("alt.wr_addr", 32'(wr_addr), 32'd2048);
        chk("alt.rd_addr", 32'(rd_addr), 32'd1536);

        // urgent write level: write wins twice in a row despite read eligible
        wr_fifo_cnt = 10'd800;
        run_burst("urg1", 1'b1, 32'd2048);
        run_burst("urg2", 1'b1, 32'd2560);
        // below urgent level the tie alternates back to read
        wr_fifo_cnt = 10'd700;
        run_burst("urg3", 1'b0, 32'd1536);
        chk("urg.wr_addr", 32'(wr_addr), 32'd3072);
        chk("urg.rd_addr", 32'(rd_addr), 32'd2048);

        // wrap to min=0 when next == max
        rd_valid = 1'b0; wr_fifo_cnt = 10'd0;
        wr_min_addr = 24'd5759488; wr_load = 1'b1;
        step();
        wr_load = 1'b0;
        chk("wrap.load_idle", 32'(wr_addr), 32'd5759488);
        wr_min_addr = 24'd0; wr_fifo_cnt = 10'd512;
        run_burst("wrap0", 1'b1, 32'd5759488);
        wr_fifo_cnt = 10'd0;
        chk("wrap0.wr_addr", 32'(wr_addr), 32'd0);
        // same, wrapping to a nonzero min
        wr_min_addr = 24'd5759488; wr_load = 1'b1;
        step();
        wr_load = 1'b0;
        wr_min_addr = 24'd1024; wr_fifo_cnt = 10'd512;
        run_burst("wrap1", 1'b1, 32'd5759488);
        wr_fifo_cnt = 10'd0;
        chk("wrap1.wr_addr", 32'(wr_addr), 32'd1024);

        // loads during a read burst: read deferred, write immediate
        rd_min_addr = 24'd4096; wr_min_addr = 24'd8192; rd_valid = 1'b1;
        wait_grant("ld", 1'b0, 32'd2048);
        ack_phase("ld", 32'd2048);
        rd_load = 1'b1; wr_load = 1'b1;
        step();
        rd_load = 1'b0; wr_load = 1'b0;
        chk("ld.wr_addr_now", 32'(wr_addr), 32'd8192);
        chk("ld.rd_addr_held", 32'(rd_addr), 32'd2048);
        chk("ld.cmd_addr", 32'(cmd_addr), 32'd2048);
        chk("ld.busy", 32'(busy), 32'd1);
        done_phase("ld");
        chk("ld.rd_addr_min", 32'(rd_addr), 32'd4096);

        // reset while a read request is pending
        wait_grant("rq", 1'b0, 32'd4096);
        rd_min_addr = 24'd16; wr_min_addr = 24'd32; rd_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstreq.cmd_rd", 32'(cmd_rd), 32'd0);
        chk("rstreq.cmd_wr", 32'(cmd_wr), 32'd0);
        chk("rstreq.busy", 32'(busy), 32'd0);
        chk("rstreq.cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rstreq.cmd_len", 32'(cmd_len), 32'd0);
        chk("rstreq.rd_addr", 32'(rd_addr), 32'd16);
        chk("rstreq.wr_addr", 32'(wr_addr), 32'd32);
        step();
        chk("rstreq.stay_idle", 32'(busy | cmd_wr | cmd_rd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
